// File: rtl/ext_intr_ctrl_if.sv
// ext_intr_ctrl_if: register access port of the external interrupt controller
interface ext_intr_ctrl_if;
   logic        req;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   modport master (output req, we, addr, wdata, input rdata, rvalid);
   modport slave (input req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/ext_intr_ctrl.sv
// ext_intr_ctrl: synchronises, latches and masks NSRC external requests into one level ext_intr (HWI0).
// Define EXT_INTR_TIMER_EN to add an internal periodic timer as edge source index NSRC.
module ext_intr_ctrl #(
   parameter int NSRC        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [NSRC-1:0] src_i,
   ext_intr_ctrl_if.slave  bus,
   output logic            ext_intr
);
`ifdef EXT_INTR_TIMER_EN
   localparam int NB = NSRC + 1;
`else
   localparam int NB = NSRC;
`endif
   logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
   logic [NSRC-1:0] s, s_d_q, edge_q, edge_d;
   logic [NB-1:0]   pending_q, pending_d, enable_q, enable_d, clr, lvl, rise, edge_eff;
   logic [31:0]     rdata_q, rdata_d, timer_rdata;
   logic            rvalid_q, ext_intr_q, wr, rd;
   logic [2:0]      a;
   logic            unused;
   assign s      = sync_q[SYNC_STAGES-1];
   assign wr     = bus.req & bus.we;
   assign rd     = bus.req & ~bus.we;
   assign a      = bus.addr[4:2];
   assign unused = ^{bus.addr[1:0], bus.wdata};
`ifdef EXT_INTR_TIMER_EN
   logic [31:0] tload_q, tload_d, cnt_q, cnt_d;
   logic        run_q, run_d, tick, active;
   always_comb begin
      tload_d = tload_q;
      run_d   = run_q;
      if (wr) begin
         if (a == 3'd5) tload_d = bus.wdata;
         if (a == 3'd6) run_d = bus.wdata[0];
      end
   end
   // Counter runs TLOAD..1, so a tick lands exactly every TLOAD cycles.
   assign active      = run_q && tload_q != '0;
   assign tick        = active && cnt_q == 32'd1;
   assign cnt_d       = !active ? '0 : (cnt_q <= 32'd1) ? tload_q : cnt_q - 32'd1;
   assign lvl         = {1'b0, s};
   assign rise        = {tick, s & ~s_d_q};
   assign edge_eff    = {1'b1, edge_q};
   assign timer_rdata = (a == 3'd5) ? tload_q : (a == 3'd6) ? {31'd0, run_q} : '0;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tload_q <= '0;
         run_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         tload_q <= tload_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign lvl         = s;
   assign rise        = s & ~s_d_q;
   assign edge_eff    = edge_q;
   assign timer_rdata = '0;
`endif
   always_comb begin
      enable_d = enable_q;
      edge_d   = edge_q;
      clr      = '0;
      if (wr) begin
         if (a == 3'd1) enable_d = bus.wdata[NB-1:0];
         if (a == 3'd2) clr = bus.wdata[NB-1:0];
         if (a == 3'd3) edge_d = bus.wdata[NSRC-1:0];
      end
      // Edge bits: a new edge beats a simultaneous clear. Level bits just follow s.
      pending_d = (edge_eff & ((pending_q & ~clr) | rise)) | (~edge_eff & lvl);
      rdata_d   = rdata_q;
      if (rd) begin
         case (a)
            3'd0:    rdata_d = 32'(pending_q);
            3'd1:    rdata_d = 32'(enable_q);
            3'd3:    rdata_d = 32'(edge_q);
            3'd4:    rdata_d = 32'(pending_q & enable_q);
            default: rdata_d = timer_rdata;
         endcase
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q     <= '0;
         s_d_q      <= '0;
         pending_q  <= '0;
         enable_q   <= '0;
         edge_q     <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         ext_intr_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], src_i};
         s_d_q      <= s;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         edge_q     <= edge_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rd;
         ext_intr_q <= |(pending_q & enable_q);
      end
   end
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign ext_intr   = ext_intr_q;
endmodule

// File: tb/tb_ext_intr_ctrl.sv
// tb_ext_intr_ctrl: directed self-checking bench for ext_intr_ctrl
module tb_ext_intr_ctrl;
   logic       clk;
   logic       resetn;
   logic [7:0] src_i;
   logic       ext_intr;
   int         n_checks;
   int         n_fail;
   ext_intr_ctrl_if bus();
   ext_intr_ctrl #(.NSRC(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn), .src_i(src_i), .bus(bus), .ext_intr(ext_intr)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
      @(posedge clk);
      #1;
      bus.req = 1'b0; bus.we = 1'b0;
   endtask
   task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic v);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      d = bus.rdata;
      v = bus.rvalid;
   endtask
   task automatic test_reset;
      logic [31:0] d;
      logic v;
      resetn = 1'b0;
      cyc(2);
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL reset_ext_intr got=%b exp=0", ext_intr); end
      n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
      resetn = 1'b1;
      cyc(1);
      bus_read(5'h00, d, v);
      n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL reset_pending got=%h v=%b exp=0 v=1", d, v); end
      bus_read(5'h04, d, v);
      n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL reset_enable got=%h v=%b exp=0 v=1", d, v); end
      bus_read(5'h0C, d, v);
      n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL reset_edge got=%h v=%b exp=0 v=1", d, v); end
      cyc(1);
      n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got=%b exp=0", bus.rvalid); end
   endtask
   task automatic test_level;
      bus_write(5'h04, 32'h01);
      src_i[0] = 1'b1;
      cyc(3);
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL level_rise_early got=%b exp=0", ext_intr); end
      cyc(1);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL level_rise got=%b exp=1", ext_intr); end
      bus_write(5'h08, 32'h01);
      cyc(3);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL level_clear_held got=%b exp=1", ext_intr); end
      src_i[0] = 1'b0;
      cyc(3);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL level_fall_early got=%b exp=1", ext_intr); end
      cyc(1);
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL level_fall got=%b exp=0", ext_intr); end
   endtask
   task automatic test_edge;
      logic [31:0] d;
      logic v;
      int lows;
      bus_write(5'h0C, 32'h04);
      bus_write(5'h04, 32'h04);
      src_i[2] = 1'b1;
      cyc(2);
      src_i[2] = 1'b0;
      cyc(4);
      bus_read(5'h00, d, v);
      n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL edge_pending got=%h exp=04", d); end
      lows = 0;
      for (int i = 0; i < 800; i++) begin
         cyc(1);
         if (ext_intr !== 1'b1) lows++;
      end
      n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL edge_hold low_cycles=%0d exp=0", lows); end
      bus_write(5'h08, 32'h04);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL edge_clear_early got=%b exp=1", ext_intr); end
      cyc(1);
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL edge_clear got=%b exp=0", ext_intr); end
   endtask
   task automatic test_collision;
      logic [31:0] d;
      logic v;
      src_i[2] = 1'b1;
      cyc(2);
      src_i[2] = 1'b0;
      cyc(6);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL coll_first got=%b exp=1", ext_intr); end
      src_i[2] = 1'b1;
      cyc(2);
      bus_write(5'h08, 32'h04);
      src_i[2] = 1'b0;
      cyc(3);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL coll_intr got=%b exp=1", ext_intr); end
      bus_read(5'h00, d, v);
      n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL coll_pending got=%h exp=04", d); end
   endtask
   task automatic test_mask;
      logic [31:0] d;
      logic v;
      bus_write(5'h04, 32'h00);
      cyc(1);
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL mask_off got=%b exp=0", ext_intr); end
      bus_read(5'h10, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mask_status got=%h exp=0", d); end
      bus_read(5'h00, d, v);
      n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL mask_pending got=%h exp=04", d); end
      bus_write(5'h04, 32'h04);
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL unmask_early got=%b exp=0", ext_intr); end
      cyc(1);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL unmask got=%b exp=1", ext_intr); end
      bus_read(5'h10, d, v);
      n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL unmask_status got=%h exp=04", d); end
   endtask
   task automatic test_back_to_back;
      logic [31:0] d;
      logic v;
      bus_write(5'h04, 32'hFFFF_FFFF);
      bus_write(5'h1C, 32'hFFFF_FFFF);
      bus_read(5'h04, d, v);
      n_checks++; if (v !== 1'b1 || d !== 32'hFF) begin n_fail++; $display("FAIL enable_width got=%h exp=ff", d); end
      bus_read(5'h0C, d, v);
      n_checks++; if (v !== 1'b1 || d !== 32'h04) begin n_fail++; $display("FAIL b2b_edge got=%h exp=04", d); end
      bus_read(5'h08, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_reads0 got=%h exp=0", d); end
      bus_read(5'h1C, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped got=%h exp=0", d); end
      cyc(2);
      n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_hold got=%h exp=0", bus.rdata); end
      bus_write(5'h0C, 32'h00);
      cyc(2);
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL edge_to_level got=%b exp=0", ext_intr); end
      bus_write(5'h04, 32'h04);
   endtask
   task automatic test_timer;
      logic [31:0] d;
      logic v;
      int n;
`ifdef EXT_INTR_TIMER_EN
      bus_write(5'h04, 32'h100);
      bus_write(5'h14, 32'd10);
      bus_write(5'h18, 32'd1);
      n = 0;
      while (ext_intr !== 1'b1 && n < 40) begin cyc(1); n++; end
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL timer_first got=%b exp=1", ext_intr); end
      bus_write(5'h08, 32'h100);
      n = 1;
      cyc(1);
      while (ext_intr !== 1'b1 && n < 40) begin cyc(1); n++; end
      n_checks++; if (n !== 10) begin n_fail++; $display("FAIL timer_period got=%0d exp=10", n); end
      bus_write(5'h18, 32'd0);
      bus_write(5'h08, 32'h100);
      n = 0;
      for (int i = 0; i < 30; i++) begin cyc(1); if (ext_intr !== 1'b0) n++; end
      n_checks++; if (n !== 0) begin n_fail++; $display("FAIL timer_stop high_cycles=%0d exp=0", n); end
      bus_read(5'h14, d, v);
      n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL tload_read got=%h exp=0a", d); end
`else
      bus_write(5'h14, 32'd10);
      bus_write(5'h18, 32'd1);
      bus_read(5'h14, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL tload_absent got=%h exp=0", d); end
      cyc(30);
      bus_read(5'h00, d, v);
      n = 0;
      n_checks++; if (d !== 32'h0 || n !== 0) begin n_fail++; $display("FAIL timer_absent_pending got=%h exp=0", d); end
`endif
   endtask
   task automatic test_async_reset;
      logic [31:0] d;
      logic v;
      src_i[2] = 1'b1;
      cyc(2);
      src_i[2] = 1'b0;
      bus_write(5'h0C, 32'h04);
      bus_write(5'h04, 32'h04);
      cyc(6);
      n_checks++; if (ext_intr !== 1'b1) begin n_fail++; $display("FAIL pre_reset got=%b exp=1", ext_intr); end
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 5'h00;
      #2 resetn = 1'b0;
      #1;
      n_checks++; if (ext_intr !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%b exp=0", ext_intr); end
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL read_dropped got=%b exp=0", bus.rvalid); end
      resetn = 1'b1;
      cyc(1);
      bus_read(5'h04, d, v);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_enable_cleared got=%h exp=0", d); end
   endtask
   initial begin
      n_checks = 0; n_fail = 0;
      src_i = '0; resetn = 1'b0;
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
      test_reset();
      test_level();
      test_edge();
      test_collision();
      test_mask();
      test_back_to_back();
      test_timer();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
